// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds NUM_CH active-low domain resets, releases them in order,
// and re-runs the sequence on software request or watchdog timeout.
module reset_sequencer #(
   parameter int NUM_CH      = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int STAGE_GAP   = 2,
   parameter int WDT_WIDTH   = 16,
   parameter int WDT_TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sw_reset_req,
   input  logic              wdt_enable,
   input  logic              wdt_kick,
   output logic [NUM_CH-1:0] core_rst_n,
   output logic              seq_busy,
   output logic [1:0]        reset_cause,
   output logic [7:0]        reset_count
);

   localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [1:0] ST_ASSERT  = 2'd0;
   localparam logic [1:0] ST_RELEASE = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_SW  = 2'b01;
   localparam logic [1:0] CAUSE_WDT = 2'b10;

   logic [1:0]           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic [WDT_WIDTH-1:0] r_wdt_cnt;
   logic [NUM_CH-1:0]    r_rst_n;
   logic                 r_busy;
   logic [1:0]           r_cause;
   logic [7:0]           r_count;

   logic [1:0]           w_state_next;
   logic [CNT_W-1:0]     w_cnt_next;
   logic [IDX_W-1:0]     w_idx_next;
   logic [WDT_WIDTH-1:0] w_wdt_next;
   logic [NUM_CH-1:0]    w_rst_n_next;
   logic                 w_busy_next;
   logic [1:0]           w_cause_next;
   logic [7:0]           w_count_next;

   logic [NUM_CH-1:0]    w_sel;
   logic                 w_wdt_fire;
   logic                 w_stage_done;
   logic                 w_idx_last;
   logic [7:0]           w_count_inc;

   // One-hot mask of the channel to release next; ASSERT uses index 0.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
      assign w_sel[gi] = (r_idx == IDX_W'(gi));
   end

   // A kick in the terminal-count cycle suppresses the timeout.
   assign w_wdt_fire   = (r_wdt_cnt == WDT_WIDTH'(WDT_TIMEOUT)) && !wdt_kick;
   assign w_stage_done = (r_state == ST_ASSERT) ? (r_cnt == CNT_W'(HOLD_CYCLES - 1))
                                                : (r_cnt == CNT_W'(STAGE_GAP - 1));
   assign w_idx_last   = (r_idx == IDX_W'(NUM_CH - 1));
   assign w_count_inc  = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_wdt_next   = '0;
      w_rst_n_next = r_rst_n;
      w_busy_next  = r_busy;
      w_cause_next = r_cause;
      w_count_next = r_count;

      case (r_state)
         ST_ASSERT, ST_RELEASE: begin
            if (sw_reset_req) begin
               w_cnt_next = '0;
               if (r_state == ST_RELEASE) begin
                  w_state_next = ST_ASSERT;
                  w_idx_next   = '0;
                  w_rst_n_next = '0;
                  w_cause_next = CAUSE_SW;
                  w_count_next = w_count_inc;
               end
            end else if (w_stage_done) begin
               w_cnt_next   = '0;
               w_rst_n_next = r_rst_n | w_sel;
               if (w_idx_last) begin
                  w_state_next = ST_RUN;
                  w_busy_next  = 1'b0;
               end else begin
                  w_state_next = ST_RELEASE;
                  w_idx_next   = r_idx + IDX_W'(1);
               end
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end

         ST_RUN: begin
            if (sw_reset_req || w_wdt_fire) begin
               w_state_next = ST_ASSERT;
               w_cnt_next   = '0;
               w_idx_next   = '0;
               w_rst_n_next = '0;
               w_busy_next  = 1'b1;
               w_cause_next = sw_reset_req ? CAUSE_SW : CAUSE_WDT;
               w_count_next = w_count_inc;
            end else if (wdt_kick) begin
               w_wdt_next = '0;
            end else if (wdt_enable) begin
               w_wdt_next = r_wdt_cnt + WDT_WIDTH'(1);
            end else begin
               w_wdt_next = r_wdt_cnt;
            end
         end

         default: begin
            w_state_next = ST_ASSERT;
            w_cnt_next   = '0;
            w_idx_next   = '0;
            w_rst_n_next = '0;
            w_busy_next  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_ASSERT;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_wdt_cnt <= '0;
         r_rst_n   <= '0;
         r_busy    <= 1'b1;
         r_cause   <= CAUSE_POR;
         r_count   <= '0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_idx     <= w_idx_next;
         r_wdt_cnt <= w_wdt_next;
         r_rst_n   <= w_rst_n_next;
         r_busy    <= w_busy_next;
         r_cause   <= w_cause_next;
         r_count   <= w_count_next;
      end
   end

   assign core_rst_n  = r_rst_n;
   assign seq_busy    = r_busy;
   assign reset_cause = r_cause;
   assign reset_count = r_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: per-edge vector table for the release/abort sequences,
// then hand-written watchdog, simultaneous-event, async-reset and saturation sequences.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sw_reset_req = 1'b0;
   logic       wdt_enable = 1'b0;
   logic       wdt_kick = 1'b0;
   logic [2:0] core_rst_n;
   logic       seq_busy;
   logic [1:0] reset_cause;
   logic [7:0] reset_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       sw;
      logic [2:0] rst_n;
      logic       busy;
      logic [1:0] cause;
      logic [7:0] count;
   } vec_t;

   vec_t vecs[$];

   reset_sequencer #(
      .NUM_CH(3), .HOLD_CYCLES(4), .STAGE_GAP(2), .WDT_WIDTH(16), .WDT_TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .sw_reset_req(sw_reset_req), .wdt_enable(wdt_enable),
      .wdt_kick(wdt_kick), .core_rst_n(core_rst_n), .seq_busy(seq_busy),
      .reset_cause(reset_cause), .reset_count(reset_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic sw, input logic [2:0] rn, input logic b,
                          input logic [1:0] c, input logic [7:0] n, input int reps);
      vec_t v;
      v.sw = sw; v.rst_n = rn; v.busy = b; v.cause = c; v.count = n;
      for (int i = 0; i < reps; i++) vecs.push_back(v);
   endtask

   // Steps until seq_busy drops; returns the number of edges taken (bounded).
   task automatic wait_run(output int n);
      n = 0;
      while (seq_busy && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) check("wait_run_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      int n;
      logic saw_busy;

      // Row k is applied before edge k after rst release and checked just after it.
      add_vec(0, 3'b000, 1, 2'd0, 8'd0, 3);
      add_vec(0, 3'b001, 1, 2'd0, 8'd0, 2);
      add_vec(0, 3'b011, 1, 2'd0, 8'd0, 2);
      add_vec(0, 3'b111, 0, 2'd0, 8'd0, 1);   // edge 8
      add_vec(1, 3'b000, 1, 2'd1, 8'd1, 1);   // edge 9: software reset from RUN
      add_vec(0, 3'b000, 1, 2'd1, 8'd1, 3);
      add_vec(0, 3'b001, 1, 2'd1, 8'd1, 2);
      add_vec(0, 3'b011, 1, 2'd1, 8'd1, 2);
      add_vec(0, 3'b111, 0, 2'd1, 8'd1, 1);   // edge 17
      add_vec(1, 3'b000, 1, 2'd1, 8'd2, 1);   // edge 18
      add_vec(0, 3'b000, 1, 2'd1, 8'd2, 3);
      add_vec(0, 3'b001, 1, 2'd1, 8'd2, 1);   // edge 22
      add_vec(1, 3'b000, 1, 2'd1, 8'd3, 1);   // edge 23: abort mid-RELEASE
      add_vec(0, 3'b000, 1, 2'd1, 8'd3, 1);
      add_vec(1, 3'b000, 1, 2'd1, 8'd3, 1);   // edge 25: request in ASSERT restarts hold only
      add_vec(0, 3'b000, 1, 2'd1, 8'd3, 3);
      add_vec(0, 3'b001, 1, 2'd1, 8'd3, 2);   // edge 29
      add_vec(0, 3'b011, 1, 2'd1, 8'd3, 2);
      add_vec(0, 3'b111, 0, 2'd1, 8'd3, 1);   // edge 33

      repeat (3) @(posedge clk);
      #1;
      check("por_rst_n", 32'(core_rst_n), 32'd0);
      check("por_busy", 32'(seq_busy), 32'd1);
      check("por_cause", 32'(reset_cause), 32'd0);
      check("por_count", 32'(reset_count), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         sw_reset_req = vecs[i].sw;
         step();
         sw_reset_req = 1'b0;
         $display("vec %0d sw=%b rst_n=%b busy=%b cause=%0d count=%0d", i + 1, vecs[i].sw,
                  core_rst_n, seq_busy, reset_cause, reset_count);
         check($sformatf("vec%0d", i + 1),
               {20'd0, core_rst_n, seq_busy, reset_cause, reset_count},
               {20'd0, vecs[i].rst_n, vecs[i].busy, vecs[i].cause, vecs[i].count});
      end

      // Watchdog timeout: unkicked, it fires 17 edges after entering RUN.
      wdt_enable = 1'b1;
      n = 0;
      while (!seq_busy && n < 100) begin
         step();
         n++;
      end
      $display("wdt timeout after %0d edges cause=%0d count=%0d", n, reset_cause, reset_count);
      check("wdt_edges", 32'(n), 32'd17);
      check("wdt_cause", 32'(reset_cause), 32'd2);
      check("wdt_count", 32'(reset_count), 32'd4);
      check("wdt_rst_n", 32'(core_rst_n), 32'd0);

      wait_run(n);
      check("wdt_rerun_edges", 32'(n), 32'd8);

      // Regular kicking keeps the watchdog quiet.
      saw_busy = 1'b0;
      for (int i = 0; i < 200; i++) begin
         wdt_kick = (i % 10 == 9);
         step();
         if (seq_busy) saw_busy = 1'b1;
      end
      wdt_kick = 1'b0;
      $display("kick loop busy_seen=%b count=%0d", saw_busy, reset_count);
      check("kick_no_reset", 32'(saw_busy), 32'd0);
      check("kick_count", 32'(reset_count), 32'd4);

      // Kick in the terminal-count cycle wins.
      repeat (16) step();
      check("tc_reached_busy", 32'(seq_busy), 32'd0);
      wdt_kick = 1'b1;
      step();
      wdt_kick = 1'b0;
      $display("kick at terminal count busy=%b count=%0d", seq_busy, reset_count);
      check("tc_kick_busy", 32'(seq_busy), 32'd0);
      check("tc_kick_count", 32'(reset_count), 32'd4);

      // Software request at terminal count: single reset attributed to software.
      repeat (16) step();
      check("tc2_reached_busy", 32'(seq_busy), 32'd0);
      sw_reset_req = 1'b1;
      step();
      sw_reset_req = 1'b0;
      $display("sw at terminal count busy=%b cause=%0d count=%0d", seq_busy, reset_cause, reset_count);
      check("tc_sw_busy", 32'(seq_busy), 32'd1);
      check("tc_sw_cause", 32'(reset_cause), 32'd1);
      check("tc_sw_count", 32'(reset_count), 32'd5);
      step();
      check("tc_sw_single", 32'(reset_count), 32'd5);

      // Async rst mid-sequence clears everything immediately.
      repeat (3) step();
      check("mid_rst_n_pre", 32'(core_rst_n), 32'b001);
      #2 rst = 1'b1;
      #1;
      $display("async rst rst_n=%b busy=%b cause=%0d count=%0d", core_rst_n, seq_busy,
               reset_cause, reset_count);
      check("async_rst_n", 32'(core_rst_n), 32'd0);
      check("async_busy", 32'(seq_busy), 32'd1);
      check("async_cause", 32'(reset_cause), 32'd0);
      check("async_count", 32'(reset_count), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_run(n);
      wdt_enable = 1'b0;
      check("async_rerun_edges", 32'(n), 32'd8);

      // Saturation of the reset counter.
      for (int k = 0; k < 260; k++) begin
         sw_reset_req = 1'b1;
         step();
         sw_reset_req = 1'b0;
         if (k == 254) check("sat_at_255", 32'(reset_count), 32'd255);
         wait_run(n);
      end
      $display("saturation count=%0d cause=%0d", reset_count, reset_cause);
      check("sat_count", 32'(reset_count), 32'd255);
      check("sat_cause", 32'(reset_cause), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised, synthesisable replacement for the hand-timed reset pulses the core benches drive today.
- Holds a configurable number of downstream reset domains in reset, then releases them one at a time at fixed gaps.
- Re-runs the full sequence on a software request or a watchdog timeout, and records the cause of the last reset.
- Sits between the board reset and the core and its peripherals; each output drives one active-low domain reset.

Parameters:
NUM_CH, 3, number of reset domains (>=1); bit 0 is released first.
HOLD_CYCLES, 4, clocks all domains stay in reset before ch0 is released (>=1).
STAGE_GAP, 2, clocks between successive channel releases (>=1).
WDT_WIDTH, 16, watchdog counter width.
WDT_TIMEOUT, 1000, watchdog terminal count (1..2^WDT_WIDTH-1).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-high master reset.
sw_reset_req  in  1  single-cycle software reset request.
wdt_enable  in  1  watchdog counts only while high.
wdt_kick  in  1  clears the watchdog counter.
core_rst_n  out  NUM_CH  active-low domain resets.
seq_busy  out  1  high while any channel is still in reset.
reset_cause  out  2  00 = power-on (rst), 01 = software, 10 = watchdog; 11 is unused.
reset_count  out  8  number of software plus watchdog resets, saturating at 255.

Behaviour:
- States: ASSERT, RELEASE, RUN. All outputs are registered.
- rst asserted, effective immediately:
  - state = ASSERT; all counters = 0.
  - core_rst_n = all 0; seq_busy = 1.
  - reset_cause = 00; reset_count = 0.
- ASSERT:
  - Hold counter increments each clock.
  - When counter == HOLD_CYCLES-1: core_rst_n[0] <= 1 and counter <= 0.
  - If NUM_CH == 1, go to RUN; otherwise go to RELEASE with next channel index = 1.
  - Result: ch0 goes high after the HOLD_CYCLES-th edge following rst deassertion.
- RELEASE:
  - Counter increments each clock.
  - When counter == STAGE_GAP-1: core_rst_n[idx] <= 1 and counter <= 0.
  - If idx == NUM_CH-1, go to RUN; otherwise idx <= idx+1.
  - Result: channel k goes high HOLD_CYCLES + k*STAGE_GAP edges after rst deassertion.
  - Released channels stay high until the next reset event.
- RUN:
  - seq_busy = 0.
  - Watchdog counter increments each clock while wdt_enable = 1 and wdt_kick = 0.
  - wdt_kick = 1 clears the counter to 0.
  - wdt_enable = 0 holds the counter.
- Reset event, RUN only, sampled at edge N:
  - Trigger is sw_reset_req = 1, or a watchdog counter == WDT_TIMEOUT with no kick that cycle.
  - Registered at edge N: core_rst_n = all 0, seq_busy = 1, state = ASSERT, hold and watchdog counters = 0.
  - reset_cause updated; reset_count incremented, saturating at 255.
- Simultaneous events:
  - Kick and timeout in the same cycle: kick wins, no reset.
  - sw_reset_req and timeout in the same cycle: one reset, cause = 01, count +1.
- sw_reset_req during RELEASE:
  - Aborts the sequence: all channels go back to 0, state = ASSERT, counters restart.
  - Cause = 01, count +1.
- sw_reset_req during ASSERT: restarts the hold counter only; cause and count unchanged.
- Watchdog counts only in RUN; the counter is held at 0 in ASSERT and RELEASE.
- rst mid-sequence overrides everything; reset_count is cleared.

Test Plan (defaults except WDT_TIMEOUT=16 where noted):
1. Power-on release:
   - Stimulus: rst high 3 cycles, then low.
   - Required: core_rst_n = 000 through edge 3; 001 after edge 4; 011 after edge 6; 111 after edge 8.
   - Required: seq_busy falls with the final release; reset_cause = 00; reset_count = 0.
2. Software reset:
   - Stimulus: in RUN, pulse sw_reset_req at edge N.
   - Required: core_rst_n = 000 after N; releases repeat at N+4/N+6/N+8.
   - Required: reset_cause = 01; reset_count = 1.
3. Watchdog timeout (WDT_TIMEOUT=16):
   - Stimulus: wdt_enable = 1, no kicks.
   - Required: reset fires 17 edges after entering RUN; reset_cause = 10; reset_count increments.
   - Stimulus: kick every 10 cycles for 200 cycles.
   - Required: no reset.
4. Simultaneous events:
   - Stimulus: kick at the terminal-count cycle.
   - Required: no reset.
   - Stimulus: sw_reset_req at the terminal-count cycle.
   - Required: single reset, cause = 01, count +1.
5. Abort mid-RELEASE:
   - Stimulus: sw_reset_req when core_rst_n = 001.
   - Required: next value 000; full sequence restarts; count +1.
   - Then: async rst mid-sequence clears reset_count to 0.
6. Saturation:
   - Stimulus: issue 260 software resets.
   - Required: reset_count holds at 255.
